// File: rtl/piso_shift_ctrl_pkg.sv
// Shared definitions for the PISO shift controller: FSM encoding and width helper.
package piso_shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAPW  = 2'd2
  } state_e;

  // Index/counter width; never below 1 so degenerate sizes still get a real vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// WIDTH-bit shift register: async clear, synchronous load (wins over shift), right shift.
module piso_shreg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift_en,
  input  logic             i_sin,
  output logic             o_sout
);

  logic [WIDTH-1:0] r_q;

  // Load has priority; shifting moves toward bit 0, filling from i_sin at the top.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift_en) begin
      r_q <= {i_sin, r_q[WIDTH-1:1]};
    end
  end

  assign o_sout = r_q[0];

endmodule

// File: rtl/piso_shift_ctrl.sv
// Round-robin arbitrated sequencer that loads one requester's word and shifts it out LSB first.
module piso_shift_ctrl
  import piso_shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned GAP   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               i_req_valid,
  input  logic [NREQ*WIDTH-1:0]         i_req_data,
  output logic [NREQ-1:0]               o_req_ready,
  output logic                          o_tx_out,
  output logic                          o_tx_frame,
  output logic [clog2_min1(NREQ)-1:0]   o_tx_src,
  output logic                          o_tx_done,
  output logic                          o_busy
);

  localparam int unsigned IW = clog2_min1(NREQ);
  localparam int unsigned CW = clog2_min1(WIDTH);
  localparam int unsigned GW = clog2_min1(GAP + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  state_e           r_state, w_state_next;
  logic [CW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_src;

  int unsigned      w_idx;
  logic             w_found;
  logic [IW-1:0]    w_winner;
  logic [NREQ-1:0]  w_grant;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_hs;
  logic             w_shifting;
  logic             w_sout;

  // Round-robin search: first valid requester at or above the pointer, wrapping explicitly.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      w_idx = 32'(r_ptr) + off;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && i_req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = IW'(w_idx);
      end
    end
  end

  // Decode the winner to a one-hot grant and pick its data lane.
  always_comb begin
    w_grant    = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_found && (w_winner == IW'(i))) begin
        w_grant[i] = 1'b1;
        w_sel_data = i_req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_hs       = (r_state == ST_IDLE) && w_found;
  assign w_shifting = (r_state == ST_SHIFT);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_hs) w_state_next = ST_SHIFT;
      ST_SHIFT: if (r_bit_cnt == '0) w_state_next = (GAP > 0) ? ST_GAPW : ST_IDLE;
      ST_GAPW:  if (r_gap_cnt == '0) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Bit/gap counters, RR pointer and source index; grant captures winner and advances pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_ptr     <= '0;
      r_src     <= '0;
    end else begin
      if (w_hs) begin
        r_bit_cnt <= CNT_LAST;
        r_src     <= w_winner;
        r_ptr     <= (w_winner == IDX_LAST) ? '0 : w_winner + 1'b1;
      end else if (w_shifting && (r_bit_cnt != '0)) begin
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end
      if (w_shifting && (r_bit_cnt == '0)) begin
        r_gap_cnt <= GAP_LOAD;
      end else if ((r_state == ST_GAPW) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  piso_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_hs),
    .i_data     (w_sel_data),
    .i_shift_en (w_shifting),
    .i_sin      (1'b0),
    .o_sout     (w_sout)
  );

  // Outputs; ready is also masked by reset so nothing is offered while reset is held.
  always_comb begin
    o_req_ready = (reset && (r_state == ST_IDLE)) ? w_grant : '0;
    o_tx_frame  = w_shifting;
    o_tx_out    = w_shifting && w_sout;
    o_tx_done   = w_shifting && (r_bit_cnt == '0);
    o_busy      = (r_state != ST_IDLE);
    o_tx_src    = r_src;
  end

endmodule
